// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline types and constants
//
// Purpose: common definitions used by the fetch stage and its queue.
//   XLEN          : address / PC width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) presented when no instruction is valid
//   fetch_entry_t : one fetch-queue entry {instr, pc}

package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched {instr, pc} entries
//
// Purpose: small circular buffer that absorbs decode stalls between the
// instruction memory and the decode stage.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, empties the queue
//   flush      in   empties the queue; wins over a same-cycle push
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   remove the head entry
//   head       out  entry at the head (undefined when count is 0)
//   count      out  number of valid entries, 0..DEPTH

module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue is only legal when the head leaves in the
    // same cycle; the caller's credit scheme keeps this from ever being
    // refused, the guard just keeps the pointers consistent.
    always_comb begin
        do_pop  = pop && (count != '0) && !flush;
        do_push = push && !flush && ((count != FULL_COUNT) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage_buf.sv
// rtl/fetch_stage_buf.sv - instruction fetch stage with PC, credit logic and fetch queue
//
// Purpose: holds the fetch PC, issues one word read per cycle to a
// synchronous one-cycle-latency instruction memory, buffers returned words
// for decode and handles redirects from execute.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   imem_en         out  read request this cycle
//   imem_addr       out  request address (current PC)
//   imem_rdata      in   read data, valid the cycle after imem_en
//   redirect_valid  in   taken branch / jump from execute
//   redirect_pc     in   new fetch PC, bits [1:0] ignored
//   id_ready        in   decode accepts the head instruction
//   id_valid        out  head instruction valid
//   id_instr        out  head instruction, NOP when not valid
//   id_pc           out  PC of head instruction (holds last value when empty)
//   id_pc_plus4     out  id_pc + 4

module fetch_stage_buf #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] last_pc_q;
    logic            inflight_q;

    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic [CW-1:0]   q_count;
    logic            q_valid;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     credit_need;
    logic            unused_bits;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (q_count)
    );

    always_comb begin
        q_valid  = (q_count != '0);
        id_valid = !rst && q_valid;
        pop      = id_valid && id_ready;

        // Slots that will be committed after this edge: queued entries plus
        // the word still in flight, minus the head decode takes now. A new
        // request is allowed only if its reply is guaranteed a slot.
        credit_need = {1'b0, q_count}
                    + {{CW{1'b0}}, inflight_q}
                    - {{CW{1'b0}}, pop};
        issue = !rst && !redirect_valid && (credit_need < DEPTH_LIMIT);

        // A reply that lands in a redirect cycle belongs to the wrong path.
        push            = !rst && !redirect_valid && inflight_q;
        push_data.instr = imem_rdata;
        push_data.pc    = req_pc_q;

        imem_en   = issue;
        imem_addr = rst ? RESET_PC : pc_q;

        id_instr    = id_valid ? head.instr : NOP_INSTR;
        id_pc       = rst ? RESET_PC : (q_valid ? head.pc : last_pc_q);
        id_pc_plus4 = id_pc + XLEN'(4);
    end

    assign unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            last_pc_q  <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc_q       <= {redirect_pc[XLEN-1:2], 2'b00};
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= issue;
                if (issue) begin
                    pc_q     <= pc_q + XLEN'(4);
                    req_pc_q <= pc_q;
                end
            end
            // Remember the last visible head so id_pc holds while empty.
            if (q_valid) begin
                last_pc_q <= head.pc;
            end
        end
    end

endmodule
